// File: rtl/move_decoder.sv
`default_nettype none
// ============================================================================
// Module   : move_decoder
// Brief    : Turns a stream of recorded {X,Y} maze locations back into 2-bit
//            direction codes (00=Y-1, 01=X+1, 10=X-1, 11=Y+1). Flags any
//            consecutive pair that is not a single orthogonal step.
// Revision : 1.0  initial release
// ============================================================================
module move_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       locIn,
    input  logic             locValid,
    input  logic             locLast,
    output logic             locReady,
    output logic [1:0]       dir,
    output logic             dirValid,
    output logic             dirLast,
    input  logic             dirReady,
    output logic [CNT_W-1:0] stepCnt,
    output logic             err,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ORIGIN = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] C_DIR_YM = 2'b00;
    localparam logic [1:0] C_DIR_XP = 2'b01;
    localparam logic [1:0] C_DIR_XM = 2'b10;
    localparam logic [1:0] C_DIR_YP = 2'b11;

    // Differences are taken one bit wider so that F->0 and 0->F show up as
    // large jumps instead of aliasing to +1/-1.
    localparam logic [4:0] C_D_ZERO = 5'h00;
    localparam logic [4:0] C_D_PLUS = 5'h01;
    localparam logic [4:0] C_D_MINUS = 5'h1F;

    state_t           state_q, state_d;
    logic [7:0]       prev_q, prev_d;
    logic [1:0]       dir_q, dir_d;
    logic             dir_valid_q, dir_valid_d;
    logic             dir_last_q, dir_last_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [4:0]       w_dx;
    logic [4:0]       w_dy;
    logic             w_legal;
    logic [1:0]       w_code;
    logic             w_loc_xfer;
    logic             w_dir_xfer;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_dx = {1'b0, locIn[7:4]} - {1'b0, prev_q[7:4]};
    assign w_dy = {1'b0, locIn[3:0]} - {1'b0, prev_q[3:0]};

    assign w_loc_xfer = locValid && locReady;
    assign w_dir_xfer = dir_valid_q && dirReady;
    assign w_cnt_inc  = (step_cnt_q == C_CNT_MAX) ? step_cnt_q : step_cnt_q + C_CNT_ONE;

    // Classify the step from the previous location to locIn.
    always_comb begin
        w_legal = 1'b1;
        w_code  = C_DIR_YM;
        if (w_dx == C_D_PLUS && w_dy == C_D_ZERO) begin
            w_code = C_DIR_XP;
        end else if (w_dx == C_D_MINUS && w_dy == C_D_ZERO) begin
            w_code = C_DIR_XM;
        end else if (w_dx == C_D_ZERO && w_dy == C_D_PLUS) begin
            w_code = C_DIR_YP;
        end else if (w_dx == C_D_ZERO && w_dy == C_D_MINUS) begin
            w_code = C_DIR_YM;
        end else begin
            w_legal = 1'b0;
        end
    end

    // Input ready depends on state and the output slot only, never on locValid.
    always_comb begin
        case (state_q)
            S_ORIGIN: locReady = 1'b1;
            S_STEP:   locReady = !dir_valid_q || dirReady;
            default:  locReady = 1'b0;
        endcase
    end

    // Next-state and output-register computation; start overrides everything.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        dir_d       = dir_q;
        dir_valid_d = dir_valid_q;
        dir_last_d  = dir_last_q;
        step_cnt_d  = step_cnt_q;
        err_d       = err_q;
        done_d      = done_q;

        if (start) begin
            state_d     = S_ORIGIN;
            dir_valid_d = 1'b0;
            dir_last_d  = 1'b0;
            step_cnt_d  = '0;
            err_d       = 1'b0;
            done_d      = 1'b0;
        end else begin
            // Consuming the pending code frees the slot; a load below may refill it.
            if (w_dir_xfer) begin
                dir_valid_d = 1'b0;
                dir_last_d  = 1'b0;
                step_cnt_d  = w_cnt_inc;
            end

            case (state_q)
                S_ORIGIN: begin
                    if (w_loc_xfer) begin
                        prev_d = locIn;
                        if (locLast) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    if (w_loc_xfer) begin
                        if (w_legal) begin
                            dir_d       = w_code;
                            dir_valid_d = 1'b1;
                            dir_last_d  = locLast;
                            prev_d      = locIn;
                            if (locLast) begin
                                state_d = S_DRAIN;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_ERROR;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_dir_xfer && dir_last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                default: begin
                    // IDLE, DONE and ERROR wait for start; a pending code
                    // in ERROR still drains through the common path above.
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prev_q      <= 8'h00;
            dir_q       <= 2'b00;
            dir_valid_q <= 1'b0;
            dir_last_q  <= 1'b0;
            step_cnt_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            dir_last_q  <= dir_last_d;
            step_cnt_q  <= step_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign dir      = dir_q;
    assign dirValid = dir_valid_q;
    assign dirLast  = dir_last_q;
    assign stepCnt  = step_cnt_q;
    assign err      = err_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_move_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_decoder
// Brief    : Self-checking bench for move_decoder: directed path table,
//            hand-written backpressure/reset/start sequences and random walks
//            checked against a coordinate-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_move_decoder;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [7:0]       locIn;
    logic             locValid;
    logic             locLast;
    logic             locReady;
    logic [1:0]       dir;
    logic             dirValid;
    logic             dirLast;
    logic             dirReady;
    logic [CNT_W-1:0] stepCnt;
    logic             err;
    logic             done;

    int checks = 0;
    int errors = 0;

    move_decoder #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .locIn    (locIn),
        .locValid (locValid),
        .locLast  (locLast),
        .locReady (locReady),
        .dir      (dir),
        .dirValid (dirValid),
        .dirLast  (dirLast),
        .dirReady (dirReady),
        .stepCnt  (stepCnt),
        .err      (err),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed path records: up to 5 locations (byte i at [8*i +: 8]) and
    // up to 4 expected codes (code i at [2*i +: 2]).
    typedef struct {
        logic [39:0] path;
        int          n;
        logic [7:0]  dirs;
        int          nd;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    logic [7:0] path_q [$];
    logic [1:0] exp_dirs [$];
    bit         exp_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] mkp(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3,
                                        input logic [7:0] b4);
        return {b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [7:0] mkd(input logic [1:0] d0, input logic [1:0] d1,
                                       input logic [1:0] d2, input logic [1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic load_vec(input int idx);
        logic [39:0] p;
        logic [7:0]  d;
        p = vecs[idx].path;
        d = vecs[idx].dirs;
        path_q.delete();
        exp_dirs.delete();
        for (int i = 0; i < vecs[idx].n; i++) path_q.push_back(p[8*i +: 8]);
        for (int i = 0; i < vecs[idx].nd; i++) exp_dirs.push_back(d[2*i +: 2]);
        exp_err = vecs[idx].exp_err;
    endtask

    // Reference model: walk the coordinates as integers and name each step.
    task automatic model_expect();
        logic [7:0] a;
        logic [7:0] b;
        int dx;
        int dy;
        exp_dirs.delete();
        exp_err = 1'b0;
        for (int i = 1; i < path_q.size(); i++) begin
            a  = path_q[i-1];
            b  = path_q[i];
            dx = int'(b[7:4]) - int'(a[7:4]);
            dy = int'(b[3:0]) - int'(a[3:0]);
            if (dx == 1 && dy == 0)       exp_dirs.push_back(2'b01);
            else if (dx == -1 && dy == 0) exp_dirs.push_back(2'b10);
            else if (dx == 0 && dy == 1)  exp_dirs.push_back(2'b11);
            else if (dx == 0 && dy == -1) exp_dirs.push_back(2'b00);
            else begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic gen_random(input int len);
        int x;
        int y;
        int nx;
        int ny;
        int d;
        bit ok;
        path_q.delete();
        x = $urandom_range(15);
        y = $urandom_range(15);
        path_q.push_back({x[3:0], y[3:0]});
        for (int i = 1; i < len; i++) begin
            if ($urandom_range(99) < 4) begin
                nx = $urandom_range(15);
                ny = $urandom_range(15);
            end else begin
                ok = 1'b0;
                nx = x;
                ny = y;
                while (!ok) begin
                    d  = $urandom_range(3);
                    nx = x;
                    ny = y;
                    case (d)
                        0:       ny = y - 1;
                        1:       nx = x + 1;
                        2:       nx = x - 1;
                        default: ny = y + 1;
                    endcase
                    ok = (nx >= 0) && (nx <= 15) && (ny >= 0) && (ny <= 15);
                end
            end
            x = nx;
            y = ny;
            path_q.push_back({x[3:0], y[3:0]});
        end
    endtask

    // Drive path_q through the decoder with random valid/ready and check
    // every transfer, ready, stall stability and the final status.
    task automatic run_path(input int rdy_pct, input int val_pct);
        int         li;
        int         k;
        int         cyc;
        int         n;
        int         nd;
        int         bad;
        int         e_rdy;
        bit         stall;
        bit         fin;
        logic [1:0] sd;
        logic       sl;
        n   = path_q.size();
        nd  = exp_dirs.size();
        bad = exp_err ? nd + 1 : -1;

        // A location offered during the start cycle must be ignored.
        start    = 1'b1;
        locValid = 1'b1;
        locIn    = 8'h99;
        locLast  = 1'b0;
        dirReady = 1'b0;
        tick();
        start = 1'b0;
        chk("start_stepCnt", stepCnt, 0);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
        chk("start_dirValid", dirValid, 0);

        li    = 0;
        k     = 0;
        cyc   = 0;
        stall = 1'b0;
        fin   = 1'b0;
        sd    = 2'b00;
        sl    = 1'b0;
        while (!fin && cyc < 5000) begin
            locValid = (li < n) && ($urandom_range(99) < val_pct);
            locIn    = (li < n) ? path_q[li] : 8'h00;
            locLast  = (li == n - 1);
            dirReady = ($urandom_range(99) < rdy_pct);
            #1;
            if (li == 0)                          e_rdy = 1;
            else if (li >= n || (bad >= 0 && li > bad)) e_rdy = 0;
            else                                  e_rdy = (!dirValid || dirReady) ? 1 : 0;
            chk("locReady", locReady, e_rdy);
            chk("err_flag", err, (bad >= 0 && li > bad) ? 1 : 0);
            if (stall) begin
                chk("stall_dirValid", dirValid, 1);
                chk("stall_dir", dir, sd);
                chk("stall_dirLast", dirLast, sl);
            end
            if (dirValid && dirReady) begin
                if (k < nd) begin
                    chk("dir", dir, exp_dirs[k]);
                    chk("dirLast", dirLast, (k == nd - 1 && !exp_err) ? 1 : 0);
                end else begin
                    chk("extra_dir", k, nd - 1);
                end
                k++;
            end
            stall = dirValid && !dirReady;
            sd    = dir;
            sl    = dirLast;
            if (locValid && locReady) li++;
            tick();
            cyc++;
            fin = (k >= nd) && (li >= n || (bad >= 0 && li > bad)) && !dirValid;
        end
        locValid = 1'b0;
        dirReady = 1'b0;
        if (!fin) chk("timeout", cyc, -1);
        #1;
        chk("dir_count", k, nd);
        chk("end_dirValid", dirValid, 0);
        chk("end_done", done, exp_err ? 0 : 1);
        chk("end_err", err, exp_err ? 1 : 0);
        chk("end_stepCnt", stepCnt, (nd > CNT_MAX) ? CNT_MAX : nd);
        chk("end_locReady", locReady, 0);
    endtask

    // Backpressure: first code held for five cycles, the rest back-to-back.
    task automatic seq_backpressure();
        start    = 1'b1;
        locValid = 1'b0;
        locLast  = 1'b0;
        dirReady = 1'b0;
        tick();
        start    = 1'b0;
        locValid = 1'b1;
        locIn    = 8'h00;
        tick();
        locIn = 8'h10;
        tick();
        locIn = 8'h11;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_dirValid", dirValid, 1);
            chk("bp_dir", dir, 1);
            chk("bp_locReady", locReady, 0);
            tick();
        end
        dirReady = 1'b1;
        #1;
        chk("bp_release_locReady", locReady, 1);
        tick();
        locIn   = 8'h21;
        locLast = 1'b1;
        #1;
        chk("bp_dir2", dir, 3);
        chk("bp_dir2_valid", dirValid, 1);
        chk("bp_cnt1", stepCnt, 1);
        tick();
        locValid = 1'b0;
        locLast  = 1'b0;
        #1;
        chk("bp_dir3", dir, 1);
        chk("bp_dir3_last", dirLast, 1);
        chk("bp_cnt2", stepCnt, 2);
        tick();
        dirReady = 1'b0;
        chk("bp_done", done, 1);
        chk("bp_cnt3", stepCnt, 3);
        chk("bp_dirValid_end", dirValid, 0);
        chk("bp_err", err, 0);
    endtask

    // Asynchronous reset with one code pending, then a full path, then start in DONE.
    task automatic seq_reset_midpath();
        start    = 1'b1;
        locValid = 1'b0;
        locLast  = 1'b0;
        dirReady = 1'b1;
        tick();
        start    = 1'b0;
        locValid = 1'b1;
        locIn    = 8'h00;
        tick();
        locIn = 8'h10;
        tick();
        locIn = 8'h11;
        tick();
        locIn = 8'h21;
        tick();
        locValid = 1'b0;
        dirReady = 1'b0;
        #1;
        chk("rm_pre_cnt", stepCnt, 2);
        chk("rm_pre_pending", dirValid, 1);
        rst = 1'b1;
        #1;
        chk("rm_dirValid", dirValid, 0);
        chk("rm_stepCnt", stepCnt, 0);
        chk("rm_err", err, 0);
        chk("rm_locReady", locReady, 0);
        #1;
        rst = 1'b0;
        tick();
        chk("rm_idle_locReady", locReady, 0);
        load_vec(0);
        run_path(100, 100);
        chk("rd_done_before", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rd_done_cleared", done, 0);
        chk("rd_cnt_cleared", stepCnt, 0);
        chk("rd_origin_ready", locReady, 1);
    endtask

    initial begin
        vecs[0] = '{mkp(8'h00, 8'h10, 8'h11, 8'h21, 8'h00), 4, mkd(2'b01, 2'b11, 2'b01, 2'b00), 3, 1'b0};
        vecs[1] = '{mkp(8'h55, 8'h54, 8'h44, 8'h45, 8'h55), 5, mkd(2'b00, 2'b10, 2'b11, 2'b01), 4, 1'b0};
        vecs[2] = '{mkp(8'h33, 8'h34, 8'h36, 8'h00, 8'h00), 3, mkd(2'b11, 2'b00, 2'b00, 2'b00), 1, 1'b1};
        vecs[3] = '{mkp(8'h34, 8'h34, 8'h00, 8'h00, 8'h00), 2, 8'h00, 0, 1'b1};
        vecs[4] = '{mkp(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00), 2, 8'h00, 0, 1'b1};
        vecs[5] = '{mkp(8'h7A, 8'h00, 8'h00, 8'h00, 8'h00), 1, 8'h00, 0, 1'b0};
        vecs[6] = '{mkp(8'h3F, 8'h30, 8'h00, 8'h00, 8'h00), 2, 8'h00, 0, 1'b1};
        vecs[7] = '{mkp(8'h05, 8'hF5, 8'h00, 8'h00, 8'h00), 2, 8'h00, 0, 1'b1};
        vecs[8] = '{mkp(8'h11, 8'h22, 8'h00, 8'h00, 8'h00), 2, 8'h00, 0, 1'b1};
        vecs[9] = '{mkp(8'hA0, 8'h90, 8'h91, 8'h81, 8'h00), 4, mkd(2'b10, 2'b11, 2'b10, 2'b00), 3, 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        locIn    = 8'h00;
        locValid = 1'b0;
        locLast  = 1'b0;
        dirReady = 1'b0;
        tick();
        tick();
        chk("rst_locReady", locReady, 0);
        chk("rst_dirValid", dirValid, 0);
        chk("rst_dirLast", dirLast, 0);
        chk("rst_dir", dir, 0);
        chk("rst_stepCnt", stepCnt, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();
        chk("idle_locReady", locReady, 0);

        for (int v = 0; v < 10; v++) begin
            load_vec(v);
            run_path(100, 100);
            load_vec(v);
            run_path(50, 70);
        end

        seq_backpressure();
        seq_reset_midpath();

        // Long zig-zag to reach counter saturation.
        path_q.delete();
        for (int i = 0; i < 258; i++) path_q.push_back((i % 2 == 0) ? 8'h00 : 8'h10);
        model_expect();
        run_path(100, 100);

        for (int r = 0; r < 40; r++) begin
            gen_random($urandom_range(2, 12));
            model_expect();
            run_path($urandom_range(30, 100), $urandom_range(40, 100));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
